// File: rtl/dma_pkg.sv
// Definitions shared by the descriptor sequencer and the DMA read/write blocks:
// command field widths, packed command layout, default chunk size and FSM states.
package dma_pkg;

   localparam int unsigned DMA_MAX_CHUNK_DEFAULT = 4096;
   localparam int unsigned DMA_BYTES_W           = 16;
   localparam int unsigned DMA_ADDR_W            = 32;
   localparam int unsigned DMA_CMD_W             = DMA_BYTES_W + DMA_ADDR_W;

   typedef logic [DMA_BYTES_W-1:0] dma_bytes_t;
   typedef logic [DMA_ADDR_W-1:0]  dma_addr_t;

   typedef struct packed {
      dma_bytes_t bytes;
      dma_addr_t  addr;
   } dma_cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_ISSUE,
      ST_DONE
   } dma_state_e;

endpackage

// File: rtl/dma_desc_sequencer_if.sv
// Descriptor handshake plus read/write command FIFO push signals of the sequencer.
interface dma_desc_sequencer_if;
   import dma_pkg::*;

   logic        desc_valid_i;
   logic        desc_ready_o;
   dma_addr_t   desc_src_addr_i;
   dma_addr_t   desc_dst_addr_i;
   logic [31:0] desc_len_i;

   logic        dma_rd_fifo_command_req_o;
   dma_bytes_t  dma_rd_bytes_to_transfer_o;
   dma_addr_t   dma_rd_addr_o;
   logic        dma_rd_fifo_full_i;

   logic        dma_wr_fifo_command_req_o;
   dma_bytes_t  dma_wr_bytes_to_transfer_o;
   dma_addr_t   dma_wr_addr_o;
   logic        dma_wr_fifo_full_i;

   logic        desc_done_o;
   logic        busy_o;

   modport slave (
      input  desc_valid_i, desc_src_addr_i, desc_dst_addr_i, desc_len_i,
      input  dma_rd_fifo_full_i, dma_wr_fifo_full_i,
      output desc_ready_o,
      output dma_rd_fifo_command_req_o, dma_rd_bytes_to_transfer_o, dma_rd_addr_o,
      output dma_wr_fifo_command_req_o, dma_wr_bytes_to_transfer_o, dma_wr_addr_o,
      output desc_done_o, busy_o
   );

   modport master (
      output desc_valid_i, desc_src_addr_i, desc_dst_addr_i, desc_len_i,
      output dma_rd_fifo_full_i, dma_wr_fifo_full_i,
      input  desc_ready_o,
      input  dma_rd_fifo_command_req_o, dma_rd_bytes_to_transfer_o, dma_rd_addr_o,
      input  dma_wr_fifo_command_req_o, dma_wr_bytes_to_transfer_o, dma_wr_addr_o,
      input  desc_done_o, busy_o
   );

endinterface

// File: rtl/dma_chunk_calc.sv
// Combinational chunk size: bytes left before the next MAX_CHUNK-aligned
// boundary of addr_i, clipped to the remaining length.
module dma_chunk_calc
   import dma_pkg::*;
#(
   parameter int unsigned MAX_CHUNK = DMA_MAX_CHUNK_DEFAULT
) (
   input  dma_addr_t   addr_i,
   input  logic [31:0] remaining_i,
   output dma_bytes_t  chunk_o
);

   localparam logic [31:0] CHUNK_SZ   = 32'(MAX_CHUNK);
   localparam logic [31:0] CHUNK_MASK = 32'(MAX_CHUNK - 1);

   logic [31:0] room;

   always_comb begin
      room    = CHUNK_SZ - (addr_i & CHUNK_MASK);
      chunk_o = (remaining_i < room) ? remaining_i[DMA_BYTES_W-1:0] : room[DMA_BYTES_W-1:0];
   end

endmodule

// File: rtl/dma_desc_sequencer.sv
// Splits one descriptor at a time into source-boundary-aligned chunks and pushes
// each chunk as a paired read/write command, then pulses descriptor completion.
module dma_desc_sequencer
   import dma_pkg::*;
#(
   parameter int unsigned MAX_CHUNK = DMA_MAX_CHUNK_DEFAULT
) (
   input logic                 clk,
   input logic                 reset,
   dma_desc_sequencer_if.slave bus
);

   dma_state_e  state_q, state_d;
   dma_addr_t   cur_src_q, cur_src_d;
   dma_addr_t   cur_dst_q, cur_dst_d;
   logic [31:0] remaining_q, remaining_d;
   dma_bytes_t  chunk_q, chunk_d;
   dma_bytes_t  chunk_calc;
   logic        issue_ok;
   dma_cmd_t    rd_cmd, wr_cmd;

   dma_chunk_calc #(.MAX_CHUNK(MAX_CHUNK)) u_chunk_calc (
      .addr_i      (cur_src_q),
      .remaining_i (remaining_q),
      .chunk_o     (chunk_calc)
   );

   // Both FIFOs must have room: a command is never pushed to only one side.
   assign issue_ok = (state_q == ST_ISSUE) && !bus.dma_rd_fifo_full_i && !bus.dma_wr_fifo_full_i;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cur_src_q   <= '0;
         cur_dst_q   <= '0;
         remaining_q <= '0;
         chunk_q     <= '0;
      end else begin
         state_q     <= state_d;
         cur_src_q   <= cur_src_d;
         cur_dst_q   <= cur_dst_d;
         remaining_q <= remaining_d;
         chunk_q     <= chunk_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cur_src_d   = cur_src_q;
      cur_dst_d   = cur_dst_q;
      remaining_d = remaining_q;
      chunk_d     = chunk_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.desc_valid_i) begin
               cur_src_d   = bus.desc_src_addr_i;
               cur_dst_d   = bus.desc_dst_addr_i;
               remaining_d = bus.desc_len_i;
               state_d     = (bus.desc_len_i == '0) ? ST_DONE : ST_CALC;
            end
         end
         ST_CALC: begin
            chunk_d = chunk_calc;
            state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (issue_ok) begin
               cur_src_d   = cur_src_q + 32'(chunk_q);
               cur_dst_d   = cur_dst_q + 32'(chunk_q);
               remaining_d = remaining_q - 32'(chunk_q);
               state_d     = (remaining_q == 32'(chunk_q)) ? ST_DONE : ST_CALC;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rd_cmd = '{bytes: chunk_q, addr: cur_src_q};
      wr_cmd = '{bytes: chunk_q, addr: cur_dst_q};
      bus.desc_ready_o               = (state_q == ST_IDLE);
      bus.busy_o                     = (state_q != ST_IDLE);
      bus.desc_done_o                = (state_q == ST_DONE);
      bus.dma_rd_fifo_command_req_o  = issue_ok;
      bus.dma_wr_fifo_command_req_o  = issue_ok;
      bus.dma_rd_bytes_to_transfer_o = rd_cmd.bytes;
      bus.dma_rd_addr_o              = rd_cmd.addr;
      bus.dma_wr_bytes_to_transfer_o = wr_cmd.bytes;
      bus.dma_wr_addr_o              = wr_cmd.addr;
   end

endmodule
